// File: rtl/cache_wb_sa.sv
// cache_wb_sa: N-way set-associative, write-back, write-allocate cache between
// a core word port and a single-ported word-wide RAM.
//
// Ports:
//   clk, reset              clock; asynchronous active-high reset
//   read_en, write_en       core request (write wins when both are set),
//                           sampled only while busy=0
//   address, write_data     core word address {tag,index,offset} and write word
//   read_data, valid        read result and one-cycle completion pulse
//   miss                    one-cycle pulse the cycle after a missing request
//   busy                    miss in service; requests are dropped meanwhile
//   mem_address             memory word address
//   mem_write_data/_en      eviction beat
//   mem_read_en             refill beat
//   mem_read_data           refill word, captured on the edge with mem_ready=1
//   mem_ready               current memory beat completes this cycle
//
// Storage lives in one cache_wb_sa_way instance per way; the top holds the
// miss FSM, the latched request and the per-set round-robin pointers.

// One way of the cache: per set a valid bit, dirty bit, tag and a block of
// words. Lookup, read and write all use the single idx/off address supplied
// by the controller.
module cache_wb_sa_way #(
  parameter int TAG_BITS  = 28,
  parameter int DATA_BITS = 32,
  parameter int IDX_W     = 2,
  parameter int OFF_W     = 2,
  parameter int SETS      = 4,
  parameter int WORDS     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IDX_W-1:0]     idx,
  input  logic [OFF_W-1:0]     off,
  input  logic [TAG_BITS-1:0]  tag,
  input  logic                 wr,
  input  logic                 set_dirty,
  input  logic                 fill,
  input  logic [DATA_BITS-1:0] wdata,
  output logic                 hit,
  output logic                 line_valid,
  output logic                 line_dirty,
  output logic [TAG_BITS-1:0]  line_tag,
  output logic [DATA_BITS-1:0] rdata
);
  logic [SETS-1:0]      vbit;
  logic [SETS-1:0]      dbit;
  logic [TAG_BITS-1:0]  tags  [SETS];
  logic [DATA_BITS-1:0] words [SETS][WORDS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vbit <= '0;
      dbit <= '0;
      for (int s = 0; s < SETS; s++) tags[s] <= '0;
    end else if (fill) begin
      // Refill completes on the last beat: block is clean until the
      // latched op (if a write) dirties it one cycle later.
      vbit[idx] <= 1'b1;
      dbit[idx] <= 1'b0;
      tags[idx] <= tag;
    end else if (wr && set_dirty) begin
      dbit[idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) words[idx][off] <= wdata;
  end

  assign line_valid = vbit[idx];
  assign line_dirty = dbit[idx];
  assign line_tag   = tags[idx];
  assign hit        = vbit[idx] && (tags[idx] == tag);
  assign rdata      = words[idx][off];
endmodule

module cache_wb_sa #(
  parameter int RAM_ADDRESS_BITS   = 32,
  parameter int CACHE_ADDRESS_BITS = 5,
  parameter int DATA_BITS          = 32,
  parameter int ASOC_BITS          = 1,
  parameter int BLOCK_BITS         = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        read_en,
  input  logic                        write_en,
  input  logic [RAM_ADDRESS_BITS-1:0] address,
  input  logic [DATA_BITS-1:0]        write_data,
  output logic [DATA_BITS-1:0]        read_data,
  output logic                        valid,
  output logic                        miss,
  output logic                        busy,
  output logic [RAM_ADDRESS_BITS-1:0] mem_address,
  output logic [DATA_BITS-1:0]        mem_write_data,
  output logic                        mem_write_en,
  output logic                        mem_read_en,
  input  logic [DATA_BITS-1:0]        mem_read_data,
  input  logic                        mem_ready
);
  localparam int INDEX_BITS = CACHE_ADDRESS_BITS - ASOC_BITS - BLOCK_BITS;
  localparam int TAG_BITS   = RAM_ADDRESS_BITS - INDEX_BITS - BLOCK_BITS;
  localparam int WAYS       = 1 << ASOC_BITS;
  localparam int SETS       = 1 << INDEX_BITS;
  localparam int WORDS      = 1 << BLOCK_BITS;
  // Zero-width fields are carried as one constant-zero bit.
  localparam int IDX_W      = (INDEX_BITS > 0) ? INDEX_BITS : 1;
  localparam int OFF_W      = (BLOCK_BITS > 0) ? BLOCK_BITS : 1;
  localparam int PTR_W      = (ASOC_BITS > 0) ? ASOC_BITS : 1;
  localparam logic [OFF_W-1:0] LAST = OFF_W'(WORDS - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] EVICT   = 2'd1;
  localparam logic [1:0] REFILL  = 2'd2;
  localparam logic [1:0] RESPOND = 2'd3;

  logic [1:0]           state;
  logic [OFF_W-1:0]     beat;
  logic [PTR_W-1:0]     ptr [SETS];

  // Latched miss request
  logic [TAG_BITS-1:0]  r_tag;
  logic [IDX_W-1:0]     r_idx;
  logic [OFF_W-1:0]     r_off;
  logic [DATA_BITS-1:0] r_wdata;
  logic                 r_write;
  logic [PTR_W-1:0]     r_vic;

  // Incoming address fields
  logic [TAG_BITS-1:0]  a_tag;
  logic [IDX_W-1:0]     a_idx;
  logic [OFF_W-1:0]     a_off;

  assign a_tag = address[RAM_ADDRESS_BITS-1 -: TAG_BITS];
  assign a_idx = (INDEX_BITS > 0) ? address[BLOCK_BITS +: IDX_W] : '0;
  assign a_off = (BLOCK_BITS > 0) ? address[0 +: OFF_W] : '0;

  // Way array signals
  logic [IDX_W-1:0]                cur_idx;
  logic [OFF_W-1:0]                cur_off;
  logic [TAG_BITS-1:0]             cur_tag;
  logic [DATA_BITS-1:0]            wdata;
  logic                            set_dirty;
  logic [WAYS-1:0]                 wr_v, fill_v, hit_v, vld_v, dirty_v;
  logic [WAYS-1:0][TAG_BITS-1:0]   tag_v;
  logic [WAYS-1:0][DATA_BITS-1:0]  rdata_v;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    cache_wb_sa_way #(
      .TAG_BITS(TAG_BITS), .DATA_BITS(DATA_BITS), .IDX_W(IDX_W),
      .OFF_W(OFF_W), .SETS(SETS), .WORDS(WORDS)
    ) u_way (
      .clk       (clk),
      .reset     (reset),
      .idx       (cur_idx),
      .off       (cur_off),
      .tag       (cur_tag),
      .wr        (wr_v[w]),
      .set_dirty (set_dirty),
      .fill      (fill_v[w]),
      .wdata     (wdata),
      .hit       (hit_v[w]),
      .line_valid(vld_v[w]),
      .line_dirty(dirty_v[w]),
      .line_tag  (tag_v[w]),
      .rdata     (rdata_v[w])
    );
  end

  // Builds {tag, index, offset} without zero-width concatenation pieces.
  function automatic logic [RAM_ADDRESS_BITS-1:0] join_addr(
    input logic [TAG_BITS-1:0] t, input logic [IDX_W-1:0] i,
    input logic [OFF_W-1:0] k);
    logic [RAM_ADDRESS_BITS-1:0] r;
    r = RAM_ADDRESS_BITS'(t) << (INDEX_BITS + BLOCK_BITS);
    if (INDEX_BITS > 0) r = r | (RAM_ADDRESS_BITS'(i) << BLOCK_BITS);
    if (BLOCK_BITS > 0) r = r | RAM_ADDRESS_BITS'(k);
    return r;
  endfunction

  // Lookup happens on the live address in IDLE, on the latched one otherwise.
  always_comb begin
    cur_idx   = (state == IDLE) ? a_idx : r_idx;
    cur_tag   = (state == IDLE) ? a_tag : r_tag;
    cur_off   = r_off;
    wdata     = r_wdata;
    if (state == IDLE) begin
      cur_off = a_off;
      wdata   = write_data;
    end else if (state == EVICT || state == REFILL) begin
      cur_off = beat;
      if (state == REFILL) wdata = mem_read_data;
    end
    set_dirty = (state != REFILL);
    wr_v      = '0;
    fill_v    = '0;
    case (state)
      IDLE:    if (write_en) wr_v = hit_v;
      REFILL:  if (mem_ready) begin
                 wr_v[r_vic] = 1'b1;
                 if (beat == LAST) fill_v[r_vic] = 1'b1;
               end
      RESPOND: if (r_write) wr_v[r_vic] = 1'b1;
      default: ;
    endcase
  end

  // Victim: lowest invalid way, else the set's round-robin pointer.
  logic [PTR_W-1:0] vic;
  logic             vic_found;
  always_comb begin
    vic       = ptr[a_idx];
    vic_found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!vic_found && !vld_v[w]) begin
        vic       = PTR_W'(w);
        vic_found = 1'b1;
      end
    end
  end

  logic [PTR_W-1:0] hit_way;
  logic             hit_found;
  always_comb begin
    hit_way   = '0;
    hit_found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit_found && hit_v[w]) begin
        hit_way   = PTR_W'(w);
        hit_found = 1'b1;
      end
    end
  end

  // Memory side is decoded from state so that reset drops strobes at once.
  always_comb begin
    mem_write_en   = (state == EVICT);
    mem_read_en    = (state == REFILL);
    mem_address    = '0;
    mem_write_data = '0;
    if (state == EVICT) begin
      mem_address    = join_addr(tag_v[r_vic], r_idx, beat);
      mem_write_data = rdata_v[r_vic];
    end else if (state == REFILL) begin
      mem_address    = join_addr(r_tag, r_idx, beat);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      beat      <= '0;
      busy      <= 1'b0;
      valid     <= 1'b0;
      miss      <= 1'b0;
      read_data <= '0;
      r_tag     <= '0;
      r_idx     <= '0;
      r_off     <= '0;
      r_wdata   <= '0;
      r_write   <= 1'b0;
      r_vic     <= '0;
      for (int s = 0; s < SETS; s++) ptr[s] <= '0;
    end else begin
      valid <= 1'b0;
      miss  <= 1'b0;
      case (state)
        IDLE: begin
          if (read_en || write_en) begin
            if (|hit_v) begin
              valid <= 1'b1;
              if (!write_en) read_data <= rdata_v[hit_way];
            end else begin
              miss    <= 1'b1;
              busy    <= 1'b1;
              r_tag   <= a_tag;
              r_idx   <= a_idx;
              r_off   <= a_off;
              r_wdata <= write_data;
              r_write <= write_en;
              r_vic   <= vic;
              beat    <= '0;
              state   <= (vld_v[vic] && dirty_v[vic]) ? EVICT : REFILL;
            end
          end
        end
        EVICT: begin
          if (mem_ready) begin
            if (beat == LAST) begin
              beat  <= '0;
              state <= REFILL;
            end else begin
              beat <= beat + 1'b1;
            end
          end
        end
        REFILL: begin
          if (mem_ready) begin
            if (beat == LAST) begin
              beat       <= '0;
              ptr[r_idx] <= (WAYS > 1) ? ptr[r_idx] + 1'b1 : '0;
              state      <= RESPOND;
            end else begin
              beat <= beat + 1'b1;
            end
          end
        end
        RESPOND: begin
          valid <= 1'b1;
          busy  <= 1'b0;
          if (!r_write) read_data <= rdata_v[r_vic];
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/cache_wb_sa.md
Name: cache_wb_sa

Overview:
- Parametrised N-way set-associative, write-back, write-allocate successor to the direct cache.
- Sits between the core request port and a single-ported word-wide RAM.
- Adds dirty tracking with block eviction, multi-word block refill, and round-robin replacement.
- Adds a valid/ready memory handshake with arbitrary stall tolerance and a busy back-pressure output.

Parameters:
- RAM_ADDRESS_BITS, 32: word-address width on both the core and memory sides.
- CACHE_ADDRESS_BITS, 5: log2 of total cache capacity in words.
- DATA_BITS, 32: word width.
- ASOC_BITS, 1: log2 of ways per set.
- BLOCK_BITS, 2: log2 of words per block.
- Derived: INDEX_BITS = CACHE_ADDRESS_BITS-ASOC_BITS-BLOCK_BITS (must be >=0).
- Derived: TAG_BITS = RAM_ADDRESS_BITS-INDEX_BITS-BLOCK_BITS.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- read_en  in  1  read request, sampled only when busy=0.
- write_en  in  1  write request, sampled only when busy=0; has priority over read_en.
- address  in  RAM_ADDRESS_BITS  word address; split as {tag, index, offset}.
- write_data  in  DATA_BITS  write word.
- read_data  out  DATA_BITS  read result, meaningful only while valid=1.
- valid  out  1  one-cycle pulse on completion of a read or write.
- miss  out  1  one-cycle pulse, the cycle after a request that missed.
- busy  out  1  high while a miss is being serviced; new requests are ignored.
- mem_address  out  RAM_ADDRESS_BITS  memory word address.
- mem_write_data  out  DATA_BITS  eviction data.
- mem_write_en  out  1  eviction write strobe.
- mem_read_en  out  1  refill read strobe.
- mem_read_data  in  DATA_BITS  refill data, valid in the cycle mem_ready=1.
- mem_ready  in  1  the current memory beat completes this cycle.

Behaviour:
- Reset: clear all valid bits, dirty bits and round-robin pointers. FSM goes to IDLE. All outputs are 0.
- Storage: per way/set, one valid bit, one dirty bit, a tag, and 2^BLOCK_BITS data words. Each set has an ASOC_BITS-wide round-robin pointer.
- FSM states: IDLE, EVICT, REFILL, RESPOND.
- IDLE: a request is accepted when read_en|write_en. Tag compare is across all ways.
- IDLE, hit: next cycle valid=1, miss=0.
  - Read hit: read_data = stored word.
  - Write hit: update the word and set dirty. No memory traffic. Hit latency is 1 cycle, with back-to-back hits every cycle.
- IDLE, miss: latch address, data and op; set busy=1.
  - Next cycle miss=1.
  - Victim selection: the lowest-numbered invalid way; otherwise the way at the set's pointer.
  - Go to EVICT if the victim is valid and dirty, else REFILL.
- EVICT: for beat k = 0..2^BLOCK_BITS-1:
  - Drive mem_write_en=1, mem_address={victim_tag, index, k}, mem_write_data=word k.
  - Hold all three stable until mem_ready=1, then advance k.
  - After the last beat, go to REFILL.
- REFILL: for beat k, drive mem_read_en=1 and mem_address={req_tag, index, k}, held until mem_ready=1.
  - Capture mem_read_data into word k on that edge.
  - After the last beat: write the tag, valid=1, dirty=0; advance the set pointer by 1 (mod 2^ASOC_BITS); go to RESPOND.
- RESPOND: perform the latched op on the now-resident block.
  - A write merges the word and sets dirty.
  - valid=1 for one cycle; a read returns the word. busy drops to 0 and the FSM returns to IDLE.
- Memory strobes: never both high. Both are 0 outside EVICT/REFILL. There is no timeout; mem_ready stalls are indefinite.
- Requests while busy=1 are dropped (no queue). The core must hold them until busy=0.
- read_en and write_en together: treated as a write.
- Reset mid-operation: immediate abort. Strobes fall asynchronously and the FSM returns to IDLE. Dirty data in flight is lost by definition.
- Degenerate ASOC_BITS=0: direct-mapped, and the pointer is unused.

Test Plan:
Defaults give 4 sets, 2 ways, 4-word blocks. The memory model has mem_ready=1 every cycle and returns mem[a]=a+0x1000 unless stated.
1. Read 0 after reset -> miss pulse; reads at 0,1,2,3; valid with read_data=0x1000. Reread 0 -> valid the next cycle, miss=0, no mem strobes.
2. Write 10 <- 0x55 -> miss; refill 8..11; valid; no mem writes. Read 10 -> hit, 0x55.
3. After 2, write 26 <- 0xAA (fills way 1), then read 42 (index 2, tag 2):
   - Evicts way 0 (block 8, dirty) with writes at 8..11, word 10=0x55.
   - Then refill 40..43; read_data=0x102A.
4. read_en=write_en=1, address 0x5001, data 0xFAFA -> handled as a write. Read 0x5001 -> 0xFAFA.
5. Hold mem_ready=0 for 5 cycles mid-refill -> mem_address/mem_read_en stable, busy=1, a read to 0 issued meanwhile is ignored (no valid).
6. Assert reset during REFILL beat 2 -> busy=0 and strobes=0 immediately. Re-request the same address -> misses again with a full refill.
